instr_fetch: RTL and testbench

Instruction fetch stage: consumer side of the 4-bit program-counter address bus. Holds a 16-word program memory written by a loader port. Accepts PC addresses through a valid/ready handshake and returns the addressed instruction word, tagged with its PC, through a two-entry skid-buffered valid/ready output toward decode. Sits between the program counter and the decoder in the 2018 CPU datapath.

---
 rtl/instr_fetch.sv | 141 ++++++++++++++
 tb/tb_instr_fetch.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: loader-written program memory, PC valid/ready intake and a
// two-entry (main + skid) output buffer toward decode. Optional macro: IFETCH_BYPASS_EN.
module instr_fetch #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              prog_done,
  input  logic [ADDR_W-1:0] pc,
  input  logic              pc_valid,
  output logic              pc_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              loaded
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              instr_valid_q, instr_valid_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
  logic              skid_valid_q, skid_valid_d;
  logic              pc_ready_q, pc_ready_d;
  logic [DATA_W-1:0] rd_word_s;
  logic              accept_s, consume_s, main_free_s;

  // Program memory: no reset so a loaded program survives reset_n.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

  // Read port, with optional same-edge write forwarding.
  always_comb begin
    rd_word_s = mem_q[pc];
`ifdef IFETCH_BYPASS_EN
    if (prog_we && (prog_addr == pc)) begin
      rd_word_s = prog_data;
    end else begin
      rd_word_s = mem_q[pc];
    end
`endif
  end

  assign accept_s    = pc_valid && pc_ready_q;
  assign consume_s   = instr_valid_q && instr_ready;
  assign main_free_s = !instr_valid_q || consume_s;

  // Next-state: FSM, main/skid buffer movement and registered pc_ready.
  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    skid_d        = skid_q;
    skid_pc_d     = skid_pc_q;
    skid_valid_d  = skid_valid_q;

    case (state_q)
      LOAD:    state_d = prog_done ? RUN : LOAD;
      RUN:     state_d = RUN;
      default: state_d = LOAD;
    endcase

    if (consume_s) begin
      if (skid_valid_q) begin
        instr_d       = skid_q;
        instr_pc_d    = skid_pc_q;
        instr_valid_d = 1'b1;
        skid_valid_d  = 1'b0;
      end else begin
        instr_valid_d = 1'b0;
      end
    end else begin
      instr_valid_d = instr_valid_q;
    end

    // accept implies skid empty (pc_ready), so skid never shifts on an accept cycle
    if (accept_s) begin
      if (main_free_s) begin
        instr_d       = rd_word_s;
        instr_pc_d    = pc;
        instr_valid_d = 1'b1;
      end else begin
        skid_d        = rd_word_s;
        skid_pc_d     = pc;
        skid_valid_d  = 1'b1;
      end
    end else begin
      skid_valid_d = skid_valid_d;
    end

    pc_ready_d = (state_d == RUN) && !skid_valid_d;
  end

  // State and buffer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= LOAD;
      instr_q       <= {DATA_W{1'b0}};
      instr_pc_q    <= {ADDR_W{1'b0}};
      instr_valid_q <= 1'b0;
      skid_q        <= {DATA_W{1'b0}};
      skid_pc_q     <= {ADDR_W{1'b0}};
      skid_valid_q  <= 1'b0;
      pc_ready_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      skid_q        <= skid_d;
      skid_pc_q     <= skid_pc_d;
      skid_valid_q  <= skid_valid_d;
      pc_ready_q    <= pc_ready_d;
    end
  end

  assign pc_ready    = pc_ready_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign loaded      = (state_q == RUN);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch: drives at negedge, samples at negedge.
module tb_instr_fetch;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic       prog_done;
  logic [3:0] pc;
  logic       pc_valid;
  logic       pc_ready;
  logic [7:0] instr;
  logic [3:0] instr_pc;
  logic       instr_valid;
  logic       instr_ready;
  logic       loaded;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_fetch #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data), .prog_done(prog_done),
    .pc(pc), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .loaded(loaded)
  );

  // Backpressure scenario, one entry per negedge: expected outputs then drive values.
  localparam logic       BP_IV  [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam logic [7:0] BP_IN  [9] = '{8'h00, 8'hA3, 8'hA3, 8'hA3, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'h00};
  localparam logic [3:0] BP_IPC [9] = '{4'd0, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4, 4'd5, 4'd6, 4'd0};
  localparam logic       BP_PR  [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam logic       BP_PV  [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam logic [3:0] BP_PC  [9] = '{4'd3, 4'd4, 4'd5, 4'd5, 4'd5, 4'd5, 4'd6, 4'd6, 4'd6};
  localparam logic       BP_IR  [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  task automatic test_reset();
    reset_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      prog_we = 1'($urandom); prog_addr = 4'($urandom); prog_data = 8'($urandom);
      prog_done = 1'($urandom); pc = 4'($urandom); pc_valid = 1'($urandom);
      instr_ready = 1'($urandom);
      checks++; if (instr !== 8'h00) begin errors++; $display("FAIL reset_instr got %h exp 00", instr); end
      checks++; if (instr_pc !== 4'h0) begin errors++; $display("FAIL reset_instr_pc got %h exp 0", instr_pc); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid got %b exp 0", instr_valid); end
      checks++; if (pc_ready !== 1'b0) begin errors++; $display("FAIL reset_pc_ready got %b exp 0", pc_ready); end
      checks++; if (loaded !== 1'b0) begin errors++; $display("FAIL reset_loaded got %b exp 0", loaded); end
    end
    @(negedge clk);
    prog_we = 1'b0; prog_done = 1'b0; pc_valid = 1'b1; pc = 4'd1; instr_ready = 1'b1;
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (pc_ready !== 1'b0) begin errors++; $display("FAIL load_pc_ready got %b exp 0", pc_ready); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL load_instr_valid got %b exp 0", instr_valid); end
    end
    pc_valid = 1'b0;
  endtask

  task automatic load_and_start();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      prog_we = 1'b1; prog_addr = 4'(i); prog_data = 8'(8'hA0 + i);
    end
    @(negedge clk);
    prog_we = 1'b0;
    checks++; if (pc_ready !== 1'b0) begin errors++; $display("FAIL pre_done_pc_ready got %b exp 0", pc_ready); end
    prog_done = 1'b1;
    @(negedge clk);
    prog_done = 1'b0;
    checks++; if (loaded !== 1'b1) begin errors++; $display("FAIL run_loaded got %b exp 1", loaded); end
    checks++; if (pc_ready !== 1'b1) begin errors++; $display("FAIL run_pc_ready got %b exp 1", pc_ready); end
  endtask

  task automatic test_streaming();
    instr_ready = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %b exp 1", i - 1, instr_valid); end
        checks++; if (instr !== 8'(8'hA0 + i - 1)) begin errors++; $display("FAIL stream_instr[%0d] got %h exp %h", i - 1, instr, 8'(8'hA0 + i - 1)); end
        checks++; if (instr_pc !== 4'(i - 1)) begin errors++; $display("FAIL stream_pc[%0d] got %h exp %h", i - 1, instr_pc, 4'(i - 1)); end
      end
      checks++; if (pc_ready !== 1'b1) begin errors++; $display("FAIL stream_pc_ready[%0d] got %b exp 1", i, pc_ready); end
      if (i < 16) begin pc_valid = 1'b1; pc = 4'(i); end
      else pc_valid = 1'b0;
    end
    @(negedge clk);
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got %b exp 0", instr_valid); end
  endtask

  task automatic test_backpressure();
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      checks++; if (instr_valid !== BP_IV[c]) begin errors++; $display("FAIL bp_valid[%0d] got %b exp %b", c, instr_valid, BP_IV[c]); end
      if (BP_IV[c]) begin
        checks++; if (instr !== BP_IN[c]) begin errors++; $display("FAIL bp_instr[%0d] got %h exp %h", c, instr, BP_IN[c]); end
        checks++; if (instr_pc !== BP_IPC[c]) begin errors++; $display("FAIL bp_pc[%0d] got %h exp %h", c, instr_pc, BP_IPC[c]); end
      end
      checks++; if (pc_ready !== BP_PR[c]) begin errors++; $display("FAIL bp_pc_ready[%0d] got %b exp %b", c, pc_ready, BP_PR[c]); end
      pc_valid = BP_PV[c]; pc = BP_PC[c]; instr_ready = BP_IR[c];
    end
  endtask

  task automatic test_collision();
    logic [7:0] exp_first;
`ifdef IFETCH_BYPASS_EN
    exp_first = 8'h22;
`else
    exp_first = 8'h11;
`endif
    @(negedge clk);
    instr_ready = 1'b1; prog_we = 1'b1; prog_addr = 4'd7; prog_data = 8'h11;
    @(negedge clk);
    pc_valid = 1'b1; pc = 4'd7; prog_data = 8'h22;
    @(negedge clk);
    pc_valid = 1'b0; prog_we = 1'b0;
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL coll_valid got %b exp 1", instr_valid); end
    checks++; if (instr !== exp_first) begin errors++; $display("FAIL coll_instr got %h exp %h", instr, exp_first); end
    checks++; if (instr_pc !== 4'd7) begin errors++; $display("FAIL coll_pc got %h exp 7", instr_pc); end
    @(negedge clk);
    pc_valid = 1'b1; pc = 4'd7;
    @(negedge clk);
    pc_valid = 1'b0;
    checks++; if (instr !== 8'h22) begin errors++; $display("FAIL coll_refetch got %h exp 22", instr); end
    @(negedge clk);
  endtask

  task automatic test_held_word();
    @(negedge clk);
    instr_ready = 1'b0; pc_valid = 1'b1; pc = 4'd2;
    @(negedge clk);
    pc_valid = 1'b0; prog_we = 1'b1; prog_addr = 4'd2; prog_data = 8'h55;
    checks++; if (instr !== 8'hA2) begin errors++; $display("FAIL held_before got %h exp a2", instr); end
    @(negedge clk);
    prog_we = 1'b0; instr_ready = 1'b1;
    checks++; if (instr !== 8'hA2) begin errors++; $display("FAIL held_after_write got %h exp a2", instr); end
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL held_valid got %b exp 1", instr_valid); end
    @(negedge clk);
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL held_drain got %b exp 0", instr_valid); end
    pc_valid = 1'b1; pc = 4'd2;
    @(negedge clk);
    pc_valid = 1'b0;
    checks++; if (instr !== 8'h55) begin errors++; $display("FAIL held_refetch got %h exp 55", instr); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    instr_ready = 1'b0; pc_valid = 1'b1; pc = 4'd0;
    @(negedge clk);
    checks++; if (pc_ready !== 1'b1) begin errors++; $display("FAIL mid_pc_ready_main got %b exp 1", pc_ready); end
    pc = 4'd1;
    @(negedge clk);
    pc_valid = 1'b0;
    checks++; if (pc_ready !== 1'b0) begin errors++; $display("FAIL mid_pc_ready_full got %b exp 0", pc_ready); end
    checks++; if (instr !== 8'hA0) begin errors++; $display("FAIL mid_instr got %h exp a0", instr); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL async_valid got %b exp 0", instr_valid); end
    checks++; if (pc_ready !== 1'b0) begin errors++; $display("FAIL async_pc_ready got %b exp 0", pc_ready); end
    checks++; if (loaded !== 1'b0) begin errors++; $display("FAIL async_loaded got %b exp 0", loaded); end
    checks++; if (instr !== 8'h00) begin errors++; $display("FAIL async_instr got %h exp 00", instr); end
    @(negedge clk);
    reset_n = 1'b1; instr_ready = 1'b1;
    @(negedge clk);
    prog_done = 1'b1;
    @(negedge clk);
    prog_done = 1'b0;
    checks++; if (pc_ready !== 1'b1) begin errors++; $display("FAIL restart_pc_ready got %b exp 1", pc_ready); end
    pc_valid = 1'b1; pc = 4'd5;
    @(negedge clk);
    pc_valid = 1'b0;
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL restart_valid got %b exp 1", instr_valid); end
    checks++; if (instr !== 8'hA5) begin errors++; $display("FAIL restart_instr got %h exp a5", instr); end
    checks++; if (instr_pc !== 4'd5) begin errors++; $display("FAIL restart_pc got %h exp 5", instr_pc); end
  endtask

  initial begin
    reset_n = 1'b0; prog_we = 1'b0; prog_addr = 4'd0; prog_data = 8'h00; prog_done = 1'b0;
    pc = 4'd0; pc_valid = 1'b0; instr_ready = 1'b0;
    test_reset();
    load_and_start();
    test_streaming();
    test_backpressure();
    test_collision();
    test_held_word();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
